// File: rtl/wb_b3_pkg.sv
// wb_b3_pkg: shared Wishbone B3 cycle-type and burst-type codes, master state and helpers
package wb_b3_pkg;
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;
  typedef enum logic {IDLE, BURST} state_t;
  function automatic logic [1:0] bte_from_beats(input int beats);
    return beats == 4 ? BTE_WRAP4 : beats == 8 ? BTE_WRAP8 : beats == 16 ? BTE_WRAP16 : BTE_LINEAR;
  endfunction
endpackage

// File: rtl/wb_wrap_adr_gen.sv
// wb_wrap_adr_gen: wrapping line address generator (fixed line base, start index, beat count)
module wb_wrap_adr_gen #(
  parameter int aw    = 32,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [aw-1:2]    adr_i,
  input  logic             adv_i,
  output logic [aw-1:0]    adr_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             last_o
);
  logic [aw-1:IDX_W+2] base_q, base_d;
  logic [IDX_W-1:0]    start_q, start_d, beat_q, beat_d;
  assign idx_o  = start_q + beat_q;
  assign last_o = &beat_q;
  assign adr_o  = {base_q, idx_o, 2'b00};
  // capture the line on request, step the beat on each accepted ack
  always_comb begin
    base_d  = load_i ? adr_i[aw-1:IDX_W+2] : base_q;
    start_d = load_i ? adr_i[IDX_W+1:2] : start_q;
    beat_d  = load_i ? '0 : adv_i ? beat_q + 1'b1 : beat_q;
  end
  // address state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q  <= '0;
      start_q <= '0;
      beat_q  <= '0;
    end else begin
      base_q  <= base_d;
      start_q <= start_d;
      beat_q  <= beat_d;
    end
  end
endmodule

// File: rtl/wb_b3_line_burst_master.sv
// wb_b3_line_burst_master: cache-line fill/write-back as one wrapping WB B3 burst; WB_LINE_BURST_WATCHDOG_EN adds an ack watchdog
module wb_b3_line_burst_master
  import wb_b3_pkg::*;
#(
  parameter int aw      = 32,
  parameter int dw      = 32,
  parameter int BEATS   = 4,
  parameter int IDX_W   = 2,
  parameter int TIMEOUT = 255
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n_i,
  input  logic             req_i,
  input  logic             req_we_i,
  input  logic [aw-1:0]    req_adr_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic             fill_we_o,
  output logic [IDX_W-1:0] fill_idx_o,
  output logic [dw-1:0]    fill_dat_o,
  output logic [IDX_W-1:0] wr_idx_o,
  input  logic [dw-1:0]    wr_dat_i,
  output logic [aw-1:0]    wb_adr_o,
  output logic [1:0]       wb_bte_o,
  output logic [2:0]       wb_cti_o,
  output logic             wb_cyc_o,
  output logic             wb_stb_o,
  output logic             wb_we_o,
  output logic [3:0]       wb_sel_o,
  output logic [dw-1:0]    wb_dat_o,
  input  logic [dw-1:0]    wb_dat_i,
  input  logic             wb_ack_i,
  input  logic             wb_err_i,
  input  logic             wb_rty_i
);
  state_t           state_q, state_d;
  logic             we_q, we_d, done_q, done_d, err_q, err_d;
  logic             cyc, load, abort, ack, last, wdog_hit, unused_bits;
  logic [aw-1:0]    adr;
  logic [IDX_W-1:0] idx;
  assign unused_bits = ^{req_adr_i[1:0], 8'(TIMEOUT)};
`ifdef WB_LINE_BURST_WATCHDOG_EN
  logic [7:0] wdog_q, wdog_d;
  assign wdog_hit = wdog_q == 8'(TIMEOUT - 1);
  // cycles since burst start or last ack
  always_comb wdog_d = (!cyc || wb_ack_i) ? '0 : wdog_q + 8'd1;
  // watchdog counter register
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) wdog_q <= '0;
    else wdog_q <= wdog_d;
  end
`else
  assign wdog_hit = 1'b0;
`endif
  assign cyc   = state_q == BURST;
  assign load  = state_q == IDLE && req_i;
  assign abort = cyc && (wb_err_i || wb_rty_i || wdog_hit);
  assign ack   = cyc && wb_ack_i && !abort;
  wb_wrap_adr_gen #(.aw(aw), .IDX_W(IDX_W)) u_adr (
    .clk(wb_clk_i), .rst_n(wb_rst_n_i), .load_i(load), .adr_i(req_adr_i[aw-1:2]),
    .adv_i(ack), .adr_o(adr), .idx_o(idx), .last_o(last)
  );
  assign busy_o     = cyc;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign wb_cyc_o   = cyc;
  assign wb_stb_o   = cyc;
  assign wb_we_o    = cyc && we_q;
  assign wb_sel_o   = cyc ? 4'hf : 4'h0;
  assign wb_adr_o   = cyc ? adr : '0;
  assign wb_bte_o   = cyc ? bte_from_beats(BEATS) : BTE_LINEAR;
  assign wb_cti_o   = cyc ? (last ? CTI_EOB : CTI_INCR) : CTI_CLASSIC;
  assign wb_dat_o   = wb_we_o ? wr_dat_i : '0;
  assign wr_idx_o   = idx;
  assign fill_we_o  = ack && !we_q;
  assign fill_idx_o = idx;
  assign fill_dat_o = fill_we_o ? wb_dat_i : '0;
  // next state: start on request, end on last ack or abort (abort beats ack)
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (load) begin
      state_d = BURST;
      we_d    = req_we_i;
    end else if (abort) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end else if (ack && last) begin
      state_d = IDLE;
      done_d  = 1'b1;
    end
  end
  // control state registers
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_wb_b3_line_burst_master.sv
// tb_wb_b3_line_burst_master: directed checks of fill, write-back, abort, reset and back-to-back bursts
module tb_wb_b3_line_burst_master;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  int tests = 0, fails = 0;

  logic req4 = 0, we4 = 0, ack_en4 = 1;
  logic [31:0] adr4 = 0;
  logic busy4, done4, err4o, fwe4, cyc4, stb4, wwe4, ack4, err4;
  logic [1:0] fidx4, widx4, bte4;
  logic [2:0] cti4;
  logic [3:0] sel4;
  logic [31:0] fdat4, wdat4, wadr4, wdo4, wdi4;
  logic [31:0] ram4 [256];
  int nack4 = 0, err_at4 = 99;

  logic req8 = 0, we8 = 0;
  logic [31:0] adr8 = 0;
  logic busy8, done8, err8o, fwe8, cyc8, stb8, wwe8, ack8;
  logic [2:0] fidx8, widx8, cti8;
  logic [1:0] bte8;
  logic [3:0] sel8;
  logic [31:0] fdat8, wdat8, wadr8, wdo8;
  logic [31:0] ram8 [256];

  assign wdat4 = 32'hB0 + 32'(widx4);
  assign wdi4  = ram4[wadr4[9:2]];
  assign ack4  = cyc4 & stb4 & ack_en4;
  assign err4  = cyc4 & stb4 & (nack4 == err_at4);
  assign wdat8 = 32'hA0 + 32'(widx8);
  assign ack8  = cyc8 & stb8;

  wb_b3_line_burst_master #(.BEATS(4), .IDX_W(2), .TIMEOUT(16)) u4 (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .req_i(req4), .req_we_i(we4), .req_adr_i(adr4),
    .busy_o(busy4), .done_o(done4), .err_o(err4o), .fill_we_o(fwe4), .fill_idx_o(fidx4),
    .fill_dat_o(fdat4), .wr_idx_o(widx4), .wr_dat_i(wdat4), .wb_adr_o(wadr4), .wb_bte_o(bte4),
    .wb_cti_o(cti4), .wb_cyc_o(cyc4), .wb_stb_o(stb4), .wb_we_o(wwe4), .wb_sel_o(sel4),
    .wb_dat_o(wdo4), .wb_dat_i(wdi4), .wb_ack_i(ack4), .wb_err_i(err4), .wb_rty_i(1'b0));

  wb_b3_line_burst_master #(.BEATS(8), .IDX_W(3)) u8 (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .req_i(req8), .req_we_i(we8), .req_adr_i(adr8),
    .busy_o(busy8), .done_o(done8), .err_o(err8o), .fill_we_o(fwe8), .fill_idx_o(fidx8),
    .fill_dat_o(fdat8), .wr_idx_o(widx8), .wr_dat_i(wdat8), .wb_adr_o(wadr8), .wb_bte_o(bte8),
    .wb_cti_o(cti8), .wb_cyc_o(cyc8), .wb_stb_o(stb8), .wb_we_o(wwe8), .wb_sel_o(sel8),
    .wb_dat_o(wdo8), .wb_dat_i(32'h0), .wb_ack_i(ack8), .wb_err_i(1'b0), .wb_rty_i(1'b0));

  // slave-side ack counter for error injection, and write-back RAM
  always @(posedge clk) begin
    nack4 <= cyc4 ? nack4 + (ack4 ? 1 : 0) : 0;
    if (ack8 && wwe8) ram8[wadr8[9:2]] <= wdo8;
  end

  task automatic start4(input logic we, input logic [31:0] a);
    @(negedge clk); req4 = 1; we4 = we; adr4 = a;
    @(negedge clk); req4 = 0;
  endtask

  task automatic test_reset;
    logic [127:0] o;
    #3;
    o = {busy4, done4, err4o, fwe4, fidx4, fdat4, wadr4, bte4, cti4, cyc4, stb4, wwe4, sel4, widx4};
    tests++; if (o !== '0) begin fails++; $display("FAIL reset_u4 got %h exp 0", o); end
    o = {96'h0, busy8, done8, err8o, cyc8, stb8, cti8, bte8, sel8};
    tests++; if (o !== '0) begin fails++; $display("FAIL reset_u8 got %h exp 0", o); end
    @(negedge clk); rst_n = 1;
  endtask

  task automatic test_fill4;
    logic [31:0] ea [4] = '{32'h108, 32'h10C, 32'h100, 32'h104};
    logic [1:0] ei [4] = '{2'd2, 2'd3, 2'd0, 2'd1};
    logic [31:0] ed [4] = '{32'h1042, 32'h1043, 32'h1040, 32'h1041};
    logic [79:0] g, e;
    start4(1'b0, 32'h108);
    for (int k = 0; k < 4; k++) begin
      g = {wadr4, cti4, bte4, fwe4, fidx4, fdat4, sel4, wwe4, busy4, done4};
      e = {ea[k], (k == 3) ? 3'b111 : 3'b010, 2'b01, 1'b1, ei[k], ed[k], 4'hf, 1'b0, 1'b1, 1'b0};
      tests++; if (g !== e) begin fails++; $display("FAIL fill4_beat%0d got %h exp %h", k, g, e); end
      @(negedge clk);
    end
    tests++; if ({done4, cyc4, stb4, busy4, cti4} !== 7'b1000000) begin
      fails++; $display("FAIL fill4_done got %b exp 1000000", {done4, cyc4, stb4, busy4, cti4}); end
    @(negedge clk);
    tests++; if (done4 !== 1'b0) begin fails++; $display("FAIL fill4_done_pulse got %b exp 0", done4); end
  endtask

  task automatic test_wb8;
    logic [75:0] g, e;
    logic [31:0] ea, ed;
    @(negedge clk); req8 = 1; we8 = 1; adr8 = 32'h21C;
    @(negedge clk); req8 = 0;
    for (int k = 0; k < 8; k++) begin
      ea = 32'h200 + 32'(((k + 7) % 8) * 4);
      ed = 32'hA0 + 32'((k + 7) % 8);
      g = {wadr8, cti8, bte8, sel8, wwe8, wdo8};
      e = {ea, (k == 7) ? 3'b111 : 3'b010, 2'b10, 4'hf, 1'b1, ed};
      tests++; if (g !== e) begin fails++; $display("FAIL wb8_beat%0d got %h exp %h", k, g, e); end
      @(negedge clk);
    end
    tests++; if ({done8, cyc8, fwe8} !== 3'b100) begin
      fails++; $display("FAIL wb8_done got %b exp 100", {done8, cyc8, fwe8}); end
    for (int i = 0; i < 8; i++) begin
      tests++; if (ram8[8'h80 + 8'(i)] !== 32'hA0 + 32'(i)) begin
        fails++; $display("FAIL wb8_ram%0d got %h exp %h", i, ram8[8'h80 + 8'(i)], 32'hA0 + 32'(i)); end
    end
  endtask

  task automatic test_err;
    err_at4 = 1;
    start4(1'b0, 32'h100);
    tests++; if ({fwe4, fidx4, fdat4} !== {1'b1, 2'd0, 32'h1040}) begin
      fails++; $display("FAIL err_beat0 got %h exp 1_0_1040", {fwe4, fidx4, fdat4}); end
    @(negedge clk);
    tests++; if ({cyc4, ack4, err4, fwe4} !== 4'b1110) begin
      fails++; $display("FAIL err_beat1_nowrite got %b exp 1110", {cyc4, ack4, err4, fwe4}); end
    @(negedge clk);
    tests++; if ({cyc4, stb4, busy4, err4o, done4, fwe4} !== 6'b000100) begin
      fails++; $display("FAIL err_abort got %b exp 000100", {cyc4, stb4, busy4, err4o, done4, fwe4}); end
    @(negedge clk);
    tests++; if ({err4o, done4, cyc4} !== 3'b000) begin
      fails++; $display("FAIL err_pulse got %b exp 000", {err4o, done4, cyc4}); end
    err_at4 = 99;
  endtask

  task automatic test_reset_mid;
    int nf = 0;
    ack_en4 = 0;
    start4(1'b0, 32'h100);
    @(negedge clk);
    tests++; if ({cyc4, busy4} !== 2'b11) begin fails++; $display("FAIL rstmid_stall got %b exp 11", {cyc4, busy4}); end
    #2 rst_n = 0;
    #1;
    tests++; if ({cyc4, stb4, busy4, done4, err4o} !== 5'b0) begin
      fails++; $display("FAIL rstmid_async got %b exp 00000", {cyc4, stb4, busy4, done4, err4o}); end
    @(negedge clk); rst_n = 1; ack_en4 = 1;
    start4(1'b0, 32'h104);
    tests++; if (wadr4 !== 32'h104) begin fails++; $display("FAIL rstmid_adr got %h exp 104", wadr4); end
    for (int c = 0; c < 10 && !done4; c++) begin
      if (fwe4) nf++;
      @(negedge clk);
    end
    tests++; if ({done4, err4o, 8'(nf)} !== {1'b1, 1'b0, 8'd4}) begin
      fails++; $display("FAIL rstmid_after done=%b err=%b fills=%0d exp 1 0 4", done4, err4o, nf); end
  endtask

  task automatic test_back_to_back;
    int c = 0;
    @(negedge clk); req4 = 1; we4 = 0; adr4 = 32'h100;
    while (!done4 && c < 12) begin @(negedge clk); c++; end
    tests++; if ({done4, cyc4, busy4} !== 3'b100) begin
      fails++; $display("FAIL b2b_first got %b exp 100", {done4, cyc4, busy4}); end
    @(negedge clk);
    tests++; if ({cyc4, done4, wadr4} !== {1'b1, 1'b0, 32'h100}) begin
      fails++; $display("FAIL b2b_restart got %b %b %h exp 1 0 100", cyc4, done4, wadr4); end
    c = 0;
    while (!done4 && c < 12) begin @(negedge clk); c++; end
    req4 = 0;
    tests++; if (c !== 4) begin fails++; $display("FAIL b2b_one_done got %0d cycles exp 4", c); end
    @(negedge clk);
    tests++; if ({cyc4, done4} !== 2'b00) begin fails++; $display("FAIL b2b_stop got %b exp 00", {cyc4, done4}); end
  endtask

`ifdef WB_LINE_BURST_WATCHDOG_EN
  task automatic test_watchdog;
    int k = 0;
    ack_en4 = 0;
    start4(1'b0, 32'h100);
    while (!err4o && k < 40) begin @(negedge clk); k++; end
    tests++; if ({err4o, cyc4, 8'(k)} !== {1'b1, 1'b0, 8'd16}) begin
      fails++; $display("FAIL watchdog err=%b cyc=%b after %0d exp 1 0 16", err4o, cyc4, k); end
    ack_en4 = 1;
  endtask
`endif

  // stimulus sequence
  initial begin
    for (int i = 0; i < 256; i++) ram4[i] = 32'h1000 + 32'(i);
    test_reset;
    test_fill4;
    test_wb8;
    test_err;
    test_reset_mid;
    test_back_to_back;
`ifdef WB_LINE_BURST_WATCHDOG_EN
    test_watchdog;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
